// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sharing of one iterative 33x33 signed multiplier.
// Optional: `define MUL_SHARE_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module mul_share_ctrl #(
   parameter int TAG_W   = 4,
   parameter bit RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [31:0]      rsp_data,
   output logic [32:0]      m_src1,
   output logic [32:0]      m_src2,
   output logic             m_in_valid,
   input  logic             m_in_ready,
   input  logic             m_out_valid,
   input  logic [63:0]      m_result
);

   localparam logic [1:0] OP_MUL   = 2'd0;
   localparam logic [1:0] OP_MULH  = 2'd1;
   localparam logic [1:0] OP_MULHU = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             r_prio;
   logic [1:0]       r_op;
   logic             r_id;
   logic [TAG_W-1:0] r_tag;
   logic [32:0]      r_src1;
   logic [32:0]      r_src2;
   logic             r_rsp_id;
   logic [TAG_W-1:0] r_rsp_tag;
   logic [31:0]      r_rsp_data;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_idle;
   logic             w_acc;
   logic [1:0]       w_op;
   logic [31:0]      w_a;
   logic [31:0]      w_b;
   logic [TAG_W-1:0] w_tag;
   logic [32:0]      w_s1;
   logic [32:0]      w_s2;
   logic             w_bypass;
   logic             w_done;

   // r_prio names the requester that wins when both are valid
   assign w_gnt0 = req0_valid & (~req1_valid | ~r_prio);
   assign w_gnt1 = req1_valid & (~req0_valid | r_prio);
   assign w_idle = (r_state == S_IDLE) & ~reset;
   assign w_acc  = w_idle & (w_gnt0 | w_gnt1);

   assign w_op  = w_gnt1 ? req1_op  : req0_op;
   assign w_a   = w_gnt1 ? req1_a   : req0_a;
   assign w_b   = w_gnt1 ? req1_b   : req0_b;
   assign w_tag = w_gnt1 ? req1_tag : req0_tag;

   assign w_s1 = {(w_op != OP_MULHU) & w_a[31], w_a};
   assign w_s2 = {((w_op == OP_MUL) | (w_op == OP_MULH)) & w_b[31], w_b};

`ifdef MUL_SHARE_ZERO_BYPASS_EN
   assign w_bypass = (w_a == 32'd0) | (w_b == 32'd0);
`else
   assign w_bypass = 1'b0;
`endif

   assign w_done = (r_state == S_BUSY) & m_out_valid;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_acc) w_next = w_bypass ? S_RESP : S_ISSUE;
         S_ISSUE: if (m_in_ready) w_next = S_BUSY;
         S_BUSY:  if (m_out_valid) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      m_in_valid = 1'b0;
      rsp_valid  = 1'b0;
      unique case (1'b1)
         (r_state == S_IDLE): begin
            req0_ready = w_idle & w_gnt0;
            req1_ready = w_idle & w_gnt1;
         end
         (r_state == S_ISSUE): m_in_valid = 1'b1;
         (r_state == S_RESP):  rsp_valid  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio     <= RR_INIT;
         r_op       <= 2'd0;
         r_id       <= 1'b0;
         r_tag      <= '0;
         r_src1     <= 33'd0;
         r_src2     <= 33'd0;
         r_rsp_id   <= 1'b0;
         r_rsp_tag  <= '0;
         r_rsp_data <= 32'd0;
      end else begin
         if (w_acc) begin
            r_prio <= w_gnt0;
            r_op   <= w_op;
            r_id   <= w_gnt1;
            r_tag  <= w_tag;
            r_src1 <= w_s1;
            r_src2 <= w_s2;
            if (w_bypass) begin
               r_rsp_id   <= w_gnt1;
               r_rsp_tag  <= w_tag;
               r_rsp_data <= 32'd0;
            end
         end
         if (w_done) begin
            r_rsp_id   <= r_id;
            r_rsp_tag  <= r_tag;
            r_rsp_data <= (r_op == OP_MUL) ? m_result[31:0]
                                           : m_result[63:32];
         end
      end
   end

   assign m_src1   = r_src1;
   assign m_src2   = r_src2;
   assign rsp_id   = r_rsp_id;
   assign rsp_tag  = r_rsp_tag;
   assign rsp_data = r_rsp_data;

endmodule
